// File: rtl/pipelined_message_passer_pkg.sv
// Shared defaults, internal-width derivation and mode encoding for the
// pipelined TRW-S message passer.
package pipelined_message_passer_pkg;

    localparam int DEF_LABELS        = 16;
    localparam int DEF_LOG2_LABELS   = 4;
    localparam int DEF_MESSAGE_WIDTH = 6;
    localparam int DEF_DATA_WIDTH    = 8;
    localparam int DEF_STEP          = 16;
    localparam int DEF_POTTS_PENALTY = 16;
    localparam int DEF_TRUNC         = 32;
    localparam int DEF_SAT_MAX       = 32;

    // Headroom for the four-term sum plus the smoothing/cap additions.
    localparam int IW_EXTRA = 3;

    localparam logic MODE_POTTS        = 1'b0;
    localparam logic MODE_TRUNC_LINEAR = 1'b1;

    function automatic int calc_iw(input int data_width);
        return data_width + IW_EXTRA;
    endfunction

endpackage

// File: rtl/pipelined_message_passer_min_tree.sv
// Registered binary min tree: one comparison level per pipeline stage,
// all levels advancing together on the shared enable.
module pipelined_min_tree #(
    parameter int LABELS = 16,
    parameter int IW     = 11
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [LABELS*IW-1:0] in_vec,
    output logic [IW-1:0]        min_out
);

    localparam int LEVELS = $clog2(LABELS);
    localparam int NODES  = LABELS - 1;

    // Leaves occupy node slots [0, LABELS); level g starts at 2*LABELS - (LABELS >> g).
    logic [NODES*IW-1:0]          node_r;
    logic [NODES*IW-1:0]          node_next_s;
    logic [(LABELS+NODES)*IW-1:0] all_s;

    function automatic logic [IW-1:0] min2(input logic [IW-1:0] a, input logic [IW-1:0] b);
        logic [IW-1:0] r;
        if (a <= b) begin
            r = a;
        end else begin
            r = b;
        end
        return r;
    endfunction

    assign all_s   = {node_r, in_vec};
    assign min_out = node_r[(NODES-1)*IW +: IW];

    // Next value of every tree node from the previous level's registers.
    always_comb begin
        node_next_s = '0;
        for (int g = 0; g < LEVELS; g++) begin
            for (int k = 0; k < (LABELS >> (g + 1)); k++) begin
                node_next_s[(LABELS - (LABELS >> g) + k)*IW +: IW] =
                    min2(all_s[(2*LABELS - (2*LABELS >> g) + 2*k)*IW +: IW],
                         all_s[(2*LABELS - (2*LABELS >> g) + 2*k + 1)*IW +: IW]);
            end
        end
    end

    // Tree level registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            node_r <= '0;
        end else if (en) begin
            node_r <= node_next_s;
        end
    end

endmodule

// File: rtl/pipelined_message_passer.sv
// Back-pressurable TRW-S message passer: one pixel per cycle, Potts or
// truncated-linear smoothing per beat, min-normalised saturated outputs.
module pipelined_message_passer
    import pipelined_message_passer_pkg::*;
#(
    parameter int LABELS        = DEF_LABELS,
    parameter int LOG2_LABELS   = DEF_LOG2_LABELS,
    parameter int MESSAGE_WIDTH = DEF_MESSAGE_WIDTH,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int STEP          = DEF_STEP,
    parameter int POTTS_PENALTY = DEF_POTTS_PENALTY,
    parameter int TRUNC         = DEF_TRUNC,
    parameter int SAT_MAX       = DEF_SAT_MAX
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            mode,
    input  logic [LABELS*MESSAGE_WIDTH-1:0] horizontal_message_forward,
    input  logic [LABELS*MESSAGE_WIDTH-1:0] horizontal_message_backward,
    input  logic [LABELS*MESSAGE_WIDTH-1:0] vertical_message_forward,
    input  logic [LABELS*MESSAGE_WIDTH-1:0] vertical_message_backward,
    input  logic [LABELS*DATA_WIDTH-1:0]    data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [LABELS*MESSAGE_WIDTH-1:0] horizontal_out,
    output logic [LABELS*MESSAGE_WIDTH-1:0] vertical_out
);

    localparam int IW       = calc_iw(DATA_WIDTH);
    localparam int LAT      = 4 + LOG2_LABELS;
    localparam int MODE_LEN = 2 + LOG2_LABELS;
    localparam int MW       = MESSAGE_WIDTH;
    localparam int VW       = LABELS * MESSAGE_WIDTH;

    logic                         en_s;
    logic [LAT-1:0]               valid_r;
    logic [MODE_LEN-1:0]          mode_r;
    logic [VW-1:0]                hf_r;
    logic [VW-1:0]                hb_r;
    logic [VW-1:0]                vf_r;
    logic [VW-1:0]                vb_r;
    logic [LABELS*DATA_WIDTH-1:0] data_r;

    function automatic logic [IW-1:0] min2(input logic [IW-1:0] a, input logic [IW-1:0] b);
        logic [IW-1:0] r;
        if (a <= b) begin
            r = a;
        end else begin
            r = b;
        end
        return r;
    endfunction

    assign en_s      = out_ready | ~valid_r[LAT-1];
    assign in_ready  = en_s;
    assign out_valid = valid_r[LAT-1];

    // Valid and mode tags travel alongside the beat; the whole pipe freezes when en_s is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= '0;
            mode_r  <= '0;
        end else if (en_s) begin
            valid_r <= {valid_r[LAT-2:0], in_valid};
            mode_r  <= {mode_r[MODE_LEN-2:0], mode};
        end
    end

    // Input capture stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hf_r   <= '0;
            hb_r   <= '0;
            vf_r   <= '0;
            vb_r   <= '0;
            data_r <= '0;
        end else if (en_s) begin
            hf_r   <= horizontal_message_forward;
            hb_r   <= horizontal_message_backward;
            vf_r   <= vertical_message_forward;
            vb_r   <= vertical_message_backward;
            data_r <= data;
        end
    end

    // d = 0 is the horizontal direction, d = 1 the vertical one.
    for (genvar d = 0; d < 2; d++) begin : g_dir
        logic [LABELS*IW-1:0] sum_s;
        logic [LABELS*IW-1:0] sum_r;
        logic [LABELS*IW-1:0] t_s;
        logic [LABELS*IW-1:0] t_r [LOG2_LABELS];
        logic [IW-1:0]        min_s;
        logic [IW-1:0]        cap_s;
        logic [VW-1:0]        out_s;

        // Horizontal sums add the vertical-backward message, vertical sums the horizontal-backward one.
        always_comb begin
            sum_s = '0;
            for (int l = 0; l < LABELS; l++) begin
                sum_s[l*IW +: IW] = IW'(hf_r[l*MW +: MW]) + IW'(vf_r[l*MW +: MW])
                                  + IW'(data_r[l*DATA_WIDTH +: DATA_WIDTH])
                                  + IW'((d == 0) ? vb_r[l*MW +: MW] : hb_r[l*MW +: MW]);
            end
        end

        // Sum stage plus the smoothed-cost delay line that waits for the min tree.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sum_r <= '0;
                for (int i = 0; i < LOG2_LABELS; i++) begin
                    t_r[i] <= '0;
                end
            end else if (en_s) begin
                sum_r  <= sum_s;
                t_r[0] <= t_s;
                for (int i = 1; i < LOG2_LABELS; i++) begin
                    t_r[i] <= t_r[i-1];
                end
            end
        end

        pipelined_min_tree #(
            .LABELS (LABELS),
            .IW     (IW)
        ) u_min_tree (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (en_s),
            .in_vec  (sum_r),
            .min_out (min_s)
        );

        assign cap_s = min_s + ((mode_r[MODE_LEN-1] == MODE_TRUNC_LINEAR) ? IW'(TRUNC) : IW'(POTTS_PENALTY));

        for (genvar l = 0; l < LABELS; l++) begin : g_lab
            localparam int LO = (l > 0) ? l - 1 : 0;
            localparam int HI = (l < LABELS - 1) ? l + 1 : LABELS - 1;

            logic [IW-1:0] self_s;
            logic [IW-1:0] left_s;
            logic [IW-1:0] right_s;
            logic [IW-1:0] clip_s;
            logic [IW-1:0] norm_r;
            logic [MW-1:0] out_r;

            // Missing edge neighbours become all-ones so they never win the min.
            assign self_s  = sum_r[l*IW +: IW];
            assign left_s  = (l > 0) ? sum_r[LO*IW +: IW] + IW'(STEP) : {IW{1'b1}};
            assign right_s = (l < LABELS - 1) ? sum_r[HI*IW +: IW] + IW'(STEP) : {IW{1'b1}};
            assign t_s[l*IW +: IW] = (mode_r[1] == MODE_TRUNC_LINEAR)
                                   ? min2(self_s, min2(left_s, right_s)) : self_s;
            assign clip_s = min2(t_r[LOG2_LABELS-1][l*IW +: IW], cap_s) - min_s;

            // Normalise stage followed by the saturating output register.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    norm_r <= '0;
                    out_r  <= '0;
                end else if (en_s) begin
                    norm_r <= clip_s;
                    out_r  <= (norm_r > IW'(SAT_MAX)) ? MW'(SAT_MAX) : norm_r[MW-1:0];
                end
            end

            assign out_s[(l+1)*MW-1 -: MW] = out_r;
        end
    end

    assign horizontal_out = g_dir[0].out_s;
    assign vertical_out   = g_dir[1].out_s;

endmodule

// File: doc/pipelined_message_passer.md
# pipelined_message_passer

Parametrised, back-pressurable successor to the fixed 16-label message passer in the TRW-S belief-propagation datapath. Each accepted beat combines the forward messages, backward messages and unary data for one pixel into outgoing horizontal and vertical messages. Smoothing is selectable per beat: Potts or truncated linear. Results are min-normalised and saturated. It sits between the pixel/message stream reader and the message write-back buffer, and sustains one pixel per cycle.

## Interface
- LABELS, 16: label count, power of two, ≥4
- LOG2_LABELS, 4: log2(LABELS)
- MESSAGE_WIDTH, 6: bits per message label entry
- DATA_WIDTH, 8: bits per unary cost entry; must be ≥ MESSAGE_WIDTH
- STEP, 16: truncated-linear neighbour penalty
- POTTS_PENALTY, 16: Potts label-change penalty
- TRUNC, 32: truncated-linear cap
- SAT_MAX, 32: output saturation value; must be < 2^MESSAGE_WIDTH
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block accepts beat this cycle
- mode  in  1  0 = Potts, 1 = truncated linear; travels with the beat
- horizontal_message_forward, horizontal_message_backward, vertical_message_forward, vertical_message_backward  in  LABELS*MESSAGE_WIDTH each  label l occupies bits [(l+1)*MESSAGE_WIDTH-1 -: MESSAGE_WIDTH]
- data  in  LABELS*DATA_WIDTH  unary costs, same packing
- out_valid  out  1  result beat valid
- out_ready  in  1  downstream accepts result
- horizontal_out, vertical_out  out  LABELS*MESSAGE_WIDTH  normalised messages, same packing

## Operation
- Internal width IW = DATA_WIDTH+3. All sums are unsigned, zero-extended and cannot overflow.
- Per label l:
  - p = hf + vf + data
  - sh = p + vb
  - sv = p + hb
- Each direction s[] is processed independently:
  - m = min over l of s[l], computed by a binary tree; ties are irrelevant.
  - mode 0: c = m + POTTS_PENALTY; t[l] = s[l]
  - mode 1: c = m + TRUNC; t[l] = min(s[l], s[l-1]+STEP, s[l+1]+STEP). Out-of-range neighbours are ignored at l=0 and l=LABELS-1; no wrap-around.
  - out[l] = min(min(t[l], c) - m, SAT_MAX). The subtraction is non-negative by construction.
- mode is registered with the beat and pipelined alongside it. Changing mode between beats has no effect on beats already in flight.

## Timing
- Latency LAT = 4 + LOG2_LABELS cycles from acceptance (in_valid & in_ready) to out_valid. This is 8 at defaults.
- Stage 1 captures inputs. Stage 2 forms sums. Stages 3..2+LOG2_LABELS run one min-tree level each, with smoothing in stage 3 and delay registers after it. Stage 3+LOG2_LABELS applies the cap and subtracts m. Stage 4+LOG2_LABELS saturates and registers the outputs.
- Global advance enable en = out_ready | ~out_valid; in_ready = en.
  - When en=0, every stage holds, including the valid bits. No beat is dropped or duplicated.
  - Full throughput: one beat per cycle while out_ready=1.
- out_valid stays high with stable outputs until out_ready=1.
- A bubble (in_valid=0 while en=1) inserts an invalid slot; pipeline data registers may change, but only valid-tagged beats appear on the outputs.
- Reset:
  - All valid bits clear.
  - out_valid=0; horizontal_out and vertical_out are 0.
  - in_ready=1 once reset is released.
  - Beats in flight when reset asserts are discarded without output.

## Structure
- A shared package holds the defaults above, the IW derivation and the mode encoding constants MODE_POTTS=0 and MODE_TRUNC_LINEAR=1.
- Sub-module pipelined_min_tree (LABELS, IW, en): LOG2_LABELS registered levels, instantiated once per direction.
- The smoothing, cap and normalise logic is a generate loop over labels, shared in form by both directions.

## Test plan
- Reset: assert rst_n=0 mid-stream with 3 beats in flight -> out_valid=0 and outputs 0 immediately; after release no stale beats emerge and in_ready=1.
- Potts: all messages 0, data[5]=0, other data 100, mode 0 -> after 8 cycles both outputs have label 5 = 0 and all others = 16.
- Truncated linear: same stimulus, mode 1 -> labels 4 and 6 = 16, label 5 = 0, all others = 32.
- Saturation/overflow: all hf=63, data[0]=0, other data 255, mode 1, SAT_MAX overridden to 20 -> label 0 = 0, label 1 = 16, others = 20. No wraparound: internal sums reach 318 without wrapping.
- Back-pressure: stream 20 beats with alternating modes while out_ready toggles with a pseudo-random pattern -> all 20 results emerge in order, each matching the reference model, with no drop or duplicate, and outputs stable while stalled.
- Throughput: 64 back-to-back beats with out_ready=1 -> first out_valid 8 cycles after the first accept, then 64 consecutive valid cycles.
